// File: rtl/fir_sequencer.sv
// FIR sequencer: windows ADC samples, steps a coefficient ROM and an external
// MAC through one multiply-accumulate per tap, and registers the filter result.
module fir_sequencer #(
  parameter int NTAPS = 4,
  parameter int ACCW  = 34,
  parameter int AW    = 8
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            sample_valid,
  input  logic [23:0]     sample,
  output logic [AW-1:0]   coef_addr,
  input  logic [15:0]     coef_data,
  output logic            mac_en,
  output logic            mac_clr,
  output logic [15:0]     mac_a,
  output logic [15:0]     mac_b,
  input  logic [ACCW-1:0] mac_acc,
  output logic [ACCW-1:0] result,
  output logic            result_valid,
  output logic            busy,
  output logic            overrun
);

  localparam int KW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [KW-1:0] LAST = KW'(NTAPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    MAC   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_r;
  logic [15:0]       win_r [NTAPS];
  logic [KW-1:0]     k_r;
  logic [KW-1:0]     k_next_s;
  logic [KW-1:0]     rd_idx_s;
  logic              shift_s;
  logic [AW-1:0]     coef_addr_r;
  logic              mac_en_r;
  logic              mac_clr_r;
  logic [15:0]       mac_b_r;
  logic [ACCW-1:0]   result_r;
  logic              result_valid_r;
  logic              busy_r;
  logic              overrun_r;
  logic              unused_s;

  // Address fetched during MAC cycle k so its data lands in cycle k+1.
  function automatic logic [AW-1:0] addr_after(input logic [KW-1:0] k);
    if (k == LAST) begin
      return {AW{1'b0}};
    end else begin
      return AW'(k) + AW'(1);
    end
  endfunction

  assign unused_s = ^sample[7:0];
  assign shift_s  = (state_r == IDLE) && sample_valid;
  assign k_next_s = k_r + KW'(1);

  // Window slot feeding the next MAC cycle; guarded so the index never leaves the array.
  always_comb begin
    rd_idx_s = LAST;
    if (k_r == LAST) begin
      rd_idx_s = LAST;
    end else begin
      rd_idx_s = LAST - k_next_s;
    end
  end

  // Newest sample enters slot 0; samples arriving while busy never reach here.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      win_r[0] <= 16'd0;
    end else if (shift_s) begin
      win_r[0] <= sample[23:8];
    end
  end

  for (genvar i = 1; i < NTAPS; i++) begin : g_win
    // Older slots take their neighbour's value on each accepted sample.
    always_ff @(posedge clk) begin
      if (!nreset) begin
        win_r[i] <= 16'd0;
      end else if (shift_s) begin
        win_r[i] <= win_r[i-1];
      end
    end
  end

  // Sequencer FSM with all handshake outputs registered.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r        <= IDLE;
      k_r            <= {KW{1'b0}};
      coef_addr_r    <= {AW{1'b0}};
      mac_en_r       <= 1'b0;
      mac_clr_r      <= 1'b0;
      mac_b_r        <= 16'd0;
      result_r       <= {ACCW{1'b0}};
      result_valid_r <= 1'b0;
      busy_r         <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      result_valid_r <= 1'b0;
      if (sample_valid && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (sample_valid) begin
            state_r     <= FETCH;
            k_r         <= {KW{1'b0}};
            coef_addr_r <= {AW{1'b0}};
            busy_r      <= 1'b1;
          end
        end
        FETCH: begin
          state_r     <= MAC;
          k_r         <= {KW{1'b0}};
          mac_en_r    <= 1'b1;
          mac_clr_r   <= 1'b1;
          mac_b_r     <= win_r[LAST];
          coef_addr_r <= addr_after({KW{1'b0}});
        end
        MAC: begin
          mac_clr_r <= 1'b0;
          if (k_r == LAST) begin
            state_r     <= DRAIN;
            mac_en_r    <= 1'b0;
            mac_b_r     <= 16'd0;
            coef_addr_r <= {AW{1'b0}};
          end else begin
            k_r         <= k_next_s;
            mac_b_r     <= win_r[rd_idx_s];
            coef_addr_r <= addr_after(k_next_s);
          end
        end
        DRAIN: begin
          // mac_acc already reflects the final tap here.
          result_r       <= mac_acc;
          result_valid_r <= 1'b1;
          state_r        <= IDLE;
          busy_r         <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          mac_en_r  <= 1'b0;
          mac_clr_r <= 1'b0;
          mac_b_r   <= 16'd0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  // Coefficient arrives the cycle after its address, so it is gated rather than registered.
  assign mac_a        = mac_en_r ? coef_data : 16'd0;
  assign mac_b        = mac_b_r;
  assign mac_en       = mac_en_r;
  assign mac_clr      = mac_clr_r;
  assign coef_addr    = coef_addr_r;
  assign result       = result_r;
  assign result_valid = result_valid_r;
  assign busy         = busy_r;
  assign overrun      = overrun_r;

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: coefficient ROM and MAC models around the DUT, a
// timeline-based reference model checked every cycle, plus directed literals.
module tb_fir_sequencer;

  localparam int NTAPS = 4;
  localparam int ACCW  = 34;
  localparam int AW    = 8;

  logic            clk = 1'b0;
  logic            nreset = 1'b0;
  logic            sample_valid = 1'b0;
  logic [23:0]     sample = 24'd0;
  logic [AW-1:0]   coef_addr;
  logic [15:0]     coef_data = 16'd0;
  logic            mac_en;
  logic            mac_clr;
  logic [15:0]     mac_a;
  logic [15:0]     mac_b;
  logic [ACCW-1:0] mac_acc;
  logic [ACCW-1:0] result;
  logic            result_valid;
  logic            busy;
  logic            overrun;

  always #5 clk = ~clk;

  fir_sequencer #(.NTAPS(NTAPS), .ACCW(ACCW), .AW(AW)) dut (
    .clk(clk), .nreset(nreset), .sample_valid(sample_valid), .sample(sample),
    .coef_addr(coef_addr), .coef_data(coef_data), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc), .result(result),
    .result_valid(result_valid), .busy(busy), .overrun(overrun)
  );

  // Environment: synchronous coefficient ROM and the external MAC.
  logic [15:0]     rom [256];
  logic [ACCW-1:0] acc = '0;
  always @(posedge clk) coef_data <= rom[coef_addr];
  always @(posedge clk)
    if (mac_en) acc <= (mac_clr ? '0 : acc) + ACCW'(longint'($signed(mac_a)) * longint'(mac_b));
  assign mac_acc = acc;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a job starts on the edge a sample is accepted; every
  // output is a function of the number of edges elapsed since that edge.
  int              cyc = 0;
  int              jn = 0;
  bit              job = 0;
  bit              armed = 0;
  logic [15:0]     mwin [NTAPS];
  logic [ACCW-1:0] pend = '0;
  logic [ACCW-1:0] exp_res = '0;
  bit              exp_ov = 0;

  function automatic logic [ACCW-1:0] fir_sum();
    longint s = 0;
    for (int k = 0; k < NTAPS; k++)
      s += longint'($signed(rom[k])) * longint'(mwin[NTAPS-1-k]);
    return ACCW'(s);
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!nreset) begin
      armed = 1;
      job = 0;
      exp_res = '0;
      exp_ov = 0;
      for (int i = 0; i < NTAPS; i++) mwin[i] = 16'd0;
    end else begin
      if (job && (cyc - jn) == 6) exp_res = pend;
      if (sample_valid) begin
        if (!job || (cyc - jn) >= 7) begin
          for (int i = NTAPS-1; i > 0; i--) mwin[i] = mwin[i-1];
          mwin[0] = sample[23:8];
          pend = fir_sum();
          jn = cyc;
          job = 1;
        end else begin
          exp_ov = 1;
        end
      end
    end
  end

  int clr_cnt = 0;
  int en_cnt  = 0;
  int rv_cnt  = 0;

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      int d;
      bit e_busy, e_rv, e_en, e_clr;
      logic [AW-1:0] e_addr;
      logic [15:0] e_a, e_b;
      d = job ? (cyc - jn) : 100;
      e_busy = (d <= 5);
      e_rv   = (d == 6);
      e_en   = (d >= 1 && d <= NTAPS);
      e_clr  = (d == 1);
      e_addr = (d >= 1 && d < NTAPS) ? AW'(d) : '0;
      e_a    = e_en ? rom[d-1] : 16'd0;
      e_b    = e_en ? mwin[NTAPS-d] : 16'd0;
      check("busy", busy, e_busy);
      check("result_valid", result_valid, e_rv);
      check("mac_en", mac_en, e_en);
      check("mac_clr", mac_clr, e_clr);
      check("coef_addr", coef_addr, e_addr);
      check("mac_a", mac_a, e_a);
      check("mac_b", mac_b, e_b);
      check("result", result, exp_res);
      check("overrun", overrun, exp_ov);
      if (mac_clr) clr_cnt++;
      if (mac_en) en_cnt++;
      if (result_valid) rv_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    sample_valid = 1'b0;
    tick();
    tick();
    nreset = 1'b1;
  endtask

  task automatic send(input logic [23:0] s);
    sample_valid = 1'b1;
    sample = s;
    tick();
    sample_valid = 1'b0;
  endtask

  // Returns edges from the accepting edge to result_valid; bounded.
  task automatic wait_rv(output int lat);
    lat = 1;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic set_coef(input logic [15:0] c0, input logic [15:0] c1,
                          input logic [15:0] c2, input logic [15:0] c3);
    rom[0] = c0; rom[1] = c1; rom[2] = c2; rom[3] = c3;
  endtask

  initial begin
    int lat;
    int c0, e0, r0;
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    set_coef(16'd1, 16'd2, 16'd3, 16'd4);

    // Reset state
    do_reset();
    check("rst_coef_addr", coef_addr, 0);
    check("rst_mac_en", mac_en, 0);
    check("rst_mac_clr", mac_clr, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    check("rst_result", result, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // Single sample: latency and value
    send(24'h000A00);
    wait_rv(lat);
    check("lat_single", lat, 7);
    check("res_single", result, 40);
    repeat (5) tick();

    // Four spaced samples
    do_reset();
    c0 = clr_cnt; e0 = en_cnt;
    send(24'h000A00); repeat (9) tick();
    send(24'h001400); repeat (9) tick();
    send(24'h001E00); repeat (9) tick();
    send(24'h002800);
    wait_rv(lat);
    check("res_four", result, 300);
    check("clr_pulses", clr_cnt - c0, 4);
    check("en_cycles", en_cnt - e0, 16);
    repeat (3) tick();

    // Negative coefficient
    do_reset();
    set_coef(16'hFFFF, 16'd0, 16'd0, 16'd0);
    repeat (4) begin send(24'hFFFF00); repeat (9) tick(); end
    check("res_neg", result, 34'h3_FFFF_0001);

    // Overrun: second sample two cycles after the first
    do_reset();
    set_coef(16'd1, 16'd2, 16'd3, 16'd4);
    send(24'h000A00);
    tick();
    send(24'h001400);
    check("ovr_set", overrun, 1);
    wait_rv(lat);
    check("ovr_res", result, 40);
    repeat (3) tick();
    send(24'h001E00);
    wait_rv(lat);
    check("ovr_window", result, 150);
    check("ovr_sticky", overrun, 1);

    // Sample arriving in the result_valid cycle is accepted
    do_reset();
    send(24'h000A00);
    wait_rv(lat);
    send(24'h001400);
    check("b2b_no_ovr", overrun, 0);
    wait_rv(lat);
    check("b2b_lat", lat, 7);
    check("b2b_res", result, 110);
    repeat (3) tick();

    // Reset during MAC cycle 2
    do_reset();
    send(24'h000A00);
    repeat (3) tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_rv", result_valid, 0);
    r0 = rv_cnt;
    repeat (10) tick();
    check("abort_no_pulse", rv_cnt - r0, 0);
    send(24'h001400);
    wait_rv(lat);
    check("abort_window", result, 80);
    repeat (3) tick();

    // Randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < NTAPS; i++) rom[i] = 16'($urandom);
    r0 = rv_cnt;
    repeat (3000) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample = 24'($urandom);
      nreset = ($urandom_range(0, 299) != 0);
      tick();
    end
    sample_valid = 1'b0;
    nreset = 1'b1;
    repeat (12) tick();
    check("rand_results_seen", (rv_cnt - r0) > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 SHALL have parameter NTAPS, default 4, number of FIR taps (2..64).
REQ-002 SHALL have parameter ACCW, default 34, accumulator/result width (at least 32 + clog2(NTAPS)).
REQ-003 SHALL have parameter AW, default 8, coefficient address width.
REQ-004 SHALL be clocked only by `clk` and reset by `nreset`: one clock, synchronous active-low reset.
REQ-005 SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-006 SHALL have port nreset  input  1  synchronous active-low reset.
REQ-007 SHALL have port sample_valid  input  1  one-cycle strobe from the ADC that a new sample is present.
REQ-008 SHALL have port sample  input  24  raw ADC word; bits [23:8] are used.
REQ-009 SHALL have port coef_addr  output  AW  coefficient ROM address.
REQ-010 SHALL have port coef_data  input  16  signed coefficient, valid one cycle after coef_addr.
REQ-011 SHALL have port mac_en  output  1  MAC accumulate enable.
REQ-012 SHALL have port mac_clr  output  1  zero the accumulator before this product.
REQ-013 SHALL have port mac_a  output  16  signed coefficient operand.
REQ-014 SHALL have port mac_b  output  16  unsigned sample operand.
REQ-015 SHALL have port mac_acc  input  ACCW  registered MAC accumulator.
REQ-016 SHALL have port result  output  ACCW  last completed filter output.
REQ-017 SHALL have port result_valid  output  1  one-cycle pulse when result updates.
REQ-018 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-019 SHALL have port overrun  output  1  sticky flag set when a sample is dropped.

Function
REQ-020 SHALL assume this external MAC contract: when mac_en is high at a rising edge, acc <= (mac_clr ? 0 : acc) + sext(mac_a * mac_b), with mac_a signed and mac_b unsigned; mac_acc shows the new value in the next cycle.
REQ-021 SHALL keep a window win[0..NTAPS-1] of 16-bit registers, with win[0] the newest sample.
REQ-022 SHALL, on an accepted sample, load win[0] <= sample[23:8] and shift win[i] <= win[i-1].
REQ-023 SHALL compute result = sum over k=0..NTAPS-1 of coef[k] * win[NTAPS-1-k], in signed ACCW-bit arithmetic with no saturation.
REQ-024 SHALL implement an FSM with states IDLE, FETCH, MAC, DRAIN.
REQ-025 SHALL, in IDLE with sample_valid high: shift the window, set tap index k=0, and go to FETCH.
REQ-026 SHALL, in FETCH: drive coef_addr=0 with mac_en=0, then go to MAC.
REQ-027 SHALL, in MAC cycle k: drive mac_en=1, mac_clr=(k==0), mac_a=coef_data, mac_b=win[NTAPS-1-k], and coef_addr=k+1 (0 when k=NTAPS-1).
REQ-028 SHALL go from MAC to DRAIN after k=NTAPS-1.
REQ-029 SHALL, in DRAIN: drive mac_en=0, register result <= mac_acc, and go to IDLE.
REQ-030 SHALL assert result_valid for exactly the first IDLE cycle after DRAIN.
REQ-031 SHALL have a latency of NTAPS+3 cycles from the sample_valid edge to result_valid (7 cycles when NTAPS=4).
REQ-032 SHALL accept a sample_valid that arrives in the same cycle as result_valid.
REQ-033 SHALL, for sample_valid while busy: drop the sample, leave the window unchanged, set overrun=1, and not disturb the current computation.
REQ-034 SHALL keep overrun set until reset.
REQ-035 SHALL hold mac_en=0 and mac_clr=0 in all states except MAC.
REQ-036 SHALL hold mac_a and mac_b at 0 outside MAC.
REQ-037 SHALL keep result unchanged between result_valid pulses.

Reset
REQ-038 SHALL, while nreset is low at a rising edge: go to IDLE, clear all win[] to 0, k=0, result=0, result_valid=0, overrun=0, busy=0, coef_addr=0, and mac_en, mac_clr, mac_a, mac_b = 0.
REQ-039 SHALL, on reset during FETCH, MAC or DRAIN: abort the computation and produce no result_valid pulse for the aborted sample.

Verification
REQ-040 SHALL be verified by: after reset, check every output is 0 and busy=0.
REQ-041 SHALL be verified by: NTAPS=4, coef={1,2,3,4}, one sample 0x000A00 -> result_valid 7 cycles later, result=40.
REQ-042 SHALL be verified by: samples 0x000A00, 0x001400, 0x001E00, 0x002800, each spaced 10 cycles -> fourth result=300; mac_clr high only on the first MAC cycle each time.
REQ-043 SHALL be verified by: coef={-1,0,0,0}, four samples 0xFFFF00 -> result=-65535 (34'h3_FFFF_0001).
REQ-044 SHALL be verified by: second sample_valid 2 cycles after the first -> overrun=1, first result unaffected, window holds only the first sample; and sample_valid in the result_valid cycle -> accepted with no overrun.
REQ-045 SHALL be verified by: nreset low during MAC cycle 2 -> next cycle IDLE, window zeros, result=0, no result_valid pulse.
